// File: rtl/store_seq_ctrl.sv
// Store sequencer: drives memory, MDR and store-size merge control lines.
// Byte and half stores run read-modify-write (read, wait, MDR load, write,
// wait). Word stores skip the read phase. Illegal or misaligned requests
// go straight to a one-cycle error completion and never touch memory.
module store_seq_ctrl #(
  parameter int ADDR_W = 32,
  parameter int RD_LAT = 1,
  parameter int WR_LAT = 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic [1:0]        store_type_i,
  input  logic [ADDR_W-1:0] addr_i,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic              mem_rd_o,
  output logic              mem_wr_o,
  output logic              mdr_load_o,
  output logic [1:0]        store_sel_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o
);

  localparam int MAX_LAT = (RD_LAT > WR_LAT) ? RD_LAT : WR_LAT;
  localparam int CW      = (MAX_LAT < 1) ? 1 : $clog2(MAX_LAT + 1);
  // The wait states count down from LAT-1 to 0, spending LAT cycles there
  localparam logic [CW-1:0] RD_LOAD = CW'(RD_LAT - 1);
  localparam logic [CW-1:0] WR_LOAD = CW'(WR_LAT - 1);

  localparam logic [1:0] T_BYTE = 2'b00;
  localparam logic [1:0] T_HALF = 2'b01;
  localparam logic [1:0] T_WORD = 2'b10;
  localparam logic [1:0] T_ILL  = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE, S_READ, S_WAIT_RD, S_LOAD, S_WRITE, S_WAIT_WR, S_DONE, S_ERR
  } state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [1:0]        type_q, type_d;
  logic              mem_rd_q, mem_wr_q, mdr_load_q;
  logic              busy_q, done_q, err_q;
  logic [1:0]        sel_q;
  logic              req_bad;

  // Request legality: half needs even address, word needs 4-byte alignment
  always_comb begin
    req_bad = 1'b0;
    case (store_type_i)
      T_ILL:   req_bad = 1'b1;
      T_HALF:  req_bad = addr_i[0];
      T_WORD:  req_bad = (addr_i[1:0] != 2'b00);
      default: req_bad = 1'b0;
    endcase
  end

  // Next-state, latency counter and request latch
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    type_d  = type_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          // Only the word address is kept; memory is always word-addressed
          addr_d = {addr_i[ADDR_W-1:2], 2'b00};
          type_d = store_type_i;
          if (req_bad)                     state_d = S_ERR;
          else if (store_type_i == T_WORD) state_d = S_WRITE;
          else                             state_d = S_READ;
        end
      end
      S_READ: begin
        state_d = S_WAIT_RD;
        cnt_d   = RD_LOAD;
      end
      S_WAIT_RD: begin
        if (cnt_q == '0) state_d = S_LOAD;
        else             cnt_d   = cnt_q - CW'(1);
      end
      S_LOAD:  state_d = S_WRITE;
      S_WRITE: begin
        state_d = S_WAIT_WR;
        cnt_d   = WR_LOAD;
      end
      S_WAIT_WR: begin
        if (cnt_q == '0) state_d = S_DONE;
        else             cnt_d   = cnt_q - CW'(1);
      end
      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State register with outputs decoded from the next state, so every
  // strobe is a flop aligned with the state it belongs to
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      addr_q     <= '0;
      type_q     <= T_WORD;
      mem_rd_q   <= 1'b0;
      mem_wr_q   <= 1'b0;
      mdr_load_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      sel_q      <= T_WORD;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      type_q     <= type_d;
      mem_rd_q   <= (state_d == S_READ);
      mem_wr_q   <= (state_d == S_WRITE);
      mdr_load_q <= (state_d == S_LOAD);
      busy_q     <= (state_d != S_IDLE);
      done_q     <= (state_d == S_DONE) || (state_d == S_ERR);
      err_q      <= (state_d == S_ERR);
      // Merge select tracks the latched type for the whole operation
      sel_q      <= (state_d != S_IDLE) ? type_d : T_WORD;
    end
  end

  assign mem_addr_o  = addr_q;
  assign mem_rd_o    = mem_rd_q;
  assign mem_wr_o    = mem_wr_q;
  assign mdr_load_o  = mdr_load_q;
  assign store_sel_o = sel_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_store_seq_ctrl.sv
// Bench for store_seq_ctrl: two instances (RD_LAT=1 and RD_LAT=3) share
// the stimulus; a per-instance operation model predicts every output in
// every cycle from the accept cycle and the latency rules.
module tb_store_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  stype = 2'b00;
  logic [31:0] addr = '0;

  logic [31:0] ma [2];
  logic        rd [2], wr [2], ld [2], by [2], dn [2], er [2];
  logic [1:0]  sl [2];

  store_seq_ctrl #(.ADDR_W(32), .RD_LAT(1), .WR_LAT(1)) u1 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .store_type_i(stype),
    .addr_i(addr), .mem_addr_o(ma[0]), .mem_rd_o(rd[0]), .mem_wr_o(wr[0]),
    .mdr_load_o(ld[0]), .store_sel_o(sl[0]), .busy_o(by[0]), .done_o(dn[0]),
    .err_o(er[0]));

  store_seq_ctrl #(.ADDR_W(32), .RD_LAT(3), .WR_LAT(1)) u3 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .store_type_i(stype),
    .addr_i(addr), .mem_addr_o(ma[1]), .mem_rd_o(rd[1]), .mem_wr_o(wr[1]),
    .mdr_load_o(ld[1]), .store_sel_o(sl[1]), .busy_o(by[1]), .done_o(dn[1]),
    .err_o(er[1]));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  // Operation model: kind 0 = read-modify-write, 1 = word, 2 = error
  int          RL [2] = '{1, 3};
  int          WL [2] = '{1, 1};
  bit          op_v [2];
  int          op_n [2], op_d [2], op_k [2], free_at [2];
  logic [1:0]  op_t [2];
  logic [31:0] last_a [2];

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      op_v[i] = 0; free_at[i] = 0; last_a[i] = '0;
    end
  endtask

  task automatic model_accept(input int i, input int n, input logic [1:0] t, input logic [31:0] a);
    int k;
    if (t == 2'b11 || (t == 2'b01 && a[0]) || (t == 2'b10 && a[1:0] != 2'b00)) k = 2;
    else if (t == 2'b10) k = 1;
    else k = 0;
    op_v[i] = 1; op_n[i] = n; op_k[i] = k; op_t[i] = t;
    last_a[i] = {a[31:2], 2'b00};
    case (k)
      2:       op_d[i] = n + 1;
      1:       op_d[i] = n + 2 + WL[i];
      default: op_d[i] = n + 4 + RL[i] + WL[i];
    endcase
    free_at[i] = op_d[i] + 1;
  endtask

  task automatic cmp(input int i);
    int c, n, k;
    bit inop;
    c = cyc; n = op_n[i]; k = op_k[i];
    inop = op_v[i] && c > n && c <= op_d[i];
    chk($sformatf("u%0d_busy", i), 32'(by[i]), 32'(inop));
    chk($sformatf("u%0d_sel", i), 32'(sl[i]), inop ? 32'(op_t[i]) : 32'd2);
    chk($sformatf("u%0d_maddr", i), ma[i], last_a[i]);
    chk($sformatf("u%0d_rd", i), 32'(rd[i]), 32'(inop && k == 0 && c == n + 1));
    chk($sformatf("u%0d_ld", i), 32'(ld[i]), 32'(inop && k == 0 && c == n + 2 + RL[i]));
    chk($sformatf("u%0d_wr", i), 32'(wr[i]),
        32'(inop && ((k == 0 && c == n + 3 + RL[i]) || (k == 1 && c == n + 1))));
    chk($sformatf("u%0d_done", i), 32'(dn[i]), 32'(inop && c == op_d[i]));
    chk($sformatf("u%0d_err", i), 32'(er[i]), 32'(inop && c == op_d[i] && k == 2));
  endtask

  // One cycle: check outputs of this cycle, then drive inputs for it
  task automatic step(input bit st, input logic [1:0] ty, input logic [31:0] ad, input bit rs);
    bit was_on;
    @(negedge clk);
    cmp(0); cmp(1);
    was_on = rst_n;
    start = st; stype = ty; addr = ad; rst_n = rs;
    if (!rs) begin
      model_reset();
      if (was_on) begin
        #1;
        for (int i = 0; i < 2; i++) begin
          chk($sformatf("u%0d_rst_busy", i), 32'(by[i]), 32'd0);
          chk($sformatf("u%0d_rst_wr", i), 32'(wr[i]), 32'd0);
          chk($sformatf("u%0d_rst_sel", i), 32'(sl[i]), 32'd2);
        end
      end
    end else if (st) begin
      for (int i = 0; i < 2; i++)
        if (cyc >= free_at[i]) model_accept(i, cyc, ty, ad);
    end
  endtask

  task automatic req(input logic [1:0] ty, input logic [31:0] ad, input int idle);
    step(1, ty, ad, 1);
    for (int j = 0; j < idle; j++) step(0, 2'b00, 32'h0, 1);
  endtask

  initial begin
    model_reset();
    for (int j = 0; j < 3; j++) step(0, 2'b00, 32'h0, 0);
    for (int j = 0; j < 2; j++) step(0, 2'b00, 32'h0, 1);

    // Directed: byte, half, word, three rejected requests
    req(2'b00, 32'h0000_0103, 12);
    req(2'b01, 32'h0000_0202, 12);
    req(2'b10, 32'h0000_0300, 12);
    req(2'b01, 32'h0000_0201, 4);
    req(2'b10, 32'h0000_0302, 4);
    req(2'b11, 32'h0000_0400, 4);
    req(2'b00, 32'h0000_0501, 12);

    // Reset during WAIT_RD, then a fresh byte store
    step(1, 2'b00, 32'h0000_0103, 1);
    step(0, 2'b00, 32'h0, 1);
    step(0, 2'b00, 32'h0, 0);
    step(0, 2'b00, 32'h0, 0);
    step(0, 2'b00, 32'h0, 1);
    req(2'b00, 32'h0000_0607, 12);

    // start held high: one op per instance, re-accepted the cycle after done
    for (int j = 0; j < 20; j++) step(1, 2'b00, 32'h0000_0103, 1);
    for (int j = 0; j < 12; j++) step(0, 2'b00, 32'h0, 1);

    // Random traffic with occasional resets
    for (int j = 0; j < 3000; j++) begin
      logic [31:0] a;
      a = $urandom;
      if ($urandom_range(0, 199) == 0) step(0, 2'b00, 32'h0, 0);
      else step($urandom_range(0, 2) == 0, 2'($urandom_range(0, 3)), a, 1);
    end
    for (int j = 0; j < 12; j++) step(0, 2'b00, 32'h0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
